// File: rtl/pipe_gap_gen_if.sv
// Pipe-drawing handshake between the game top level, the gap generator and
// the pipe renderer. All signals live in the pixel clock domain.
//   Start         game top -> generator : 1-cycle pulse, begin a new game
//   Status        game top -> generator : 1 = bird alive, 0 = collision
//   PipesPosition renderer -> generator : current pipe X
//   PipesLong     generator -> renderer : top-pipe gap height
//   NewPipe       generator -> renderer : pulse one cycle after PipesLong updates
//   Score         generator -> game top : BCD {tens,units}
//   ScoreStrobe   generator -> game top : pulse when Score increments
// master = generator side, slave = the surrounding consumers/producers.
interface pipe_gap_gen_if;
  logic        Start;
  logic        Status;
  logic [15:0] PipesPosition;
  logic [15:0] PipesLong;
  logic        NewPipe;
  logic [7:0]  Score;
  logic        ScoreStrobe;

  modport master (
    input  Start, Status, PipesPosition,
    output PipesLong, NewPipe, Score, ScoreStrobe
  );

  modport slave (
    output Start, Status, PipesPosition,
    input  PipesLong, NewPipe, Score, ScoreStrobe
  );
endinterface

// File: rtl/pipe_gap_gen.sv
// Pipe gap generator: supplies the renderer with a pseudo-random top-pipe gap
// height each time the pipe re-enters at the right edge, detects the bird
// passing a pipe and keeps the 2-digit BCD score.
// Ports:
//   clk   - pixel clock, single domain
//   Reset - synchronous, active-high
//   bus   - pipe_gap_gen_if.master (Start, Status, PipesPosition in;
//           PipesLong, NewPipe, Score, ScoreStrobe out)
module pipe_gap_gen #(
  parameter logic [15:0] SEED   = 16'hACE1,
  parameter int          MIN_H  = 40,
  parameter int          SPAN   = 200,
  parameter int          DEF_H  = 140,
  parameter int          WRAP_X = 640,
  parameter int          BIRD_X = 200,
  parameter int          PIPE_W = 90
) (
  input logic            clk,
  input logic            Reset,
  pipe_gap_gen_if.master bus
);

  typedef enum logic [1:0] {WAIT_START, GEN, RUN, DEAD} state_t;

  state_t      state, nextState;
  logic [15:0] lfsr;
  logic [15:0] prevPos;
  logic        scored;

  logic wrap, pass;
  logic loadHeight, doScore, clrScore;

  // Right-shift Galois LFSR, taps x^16+x^14+x^13+x^11+1 (maximal length).
  function automatic logic [15:0] lfsrStep(input logic [15:0] v);
    return {1'b0, v[15:1]} ^ (v[0] ? 16'hB400 : 16'h0000);
  endfunction

  // Fold an 8-bit sample into 0..SPAN with a single conditional subtract,
  // then offset by MIN_H.
  function automatic logic [15:0] heightOf(input logic [7:0] s);
    logic [7:0] spanC;
    logic [7:0] f;
    spanC = 8'(SPAN);
    f = (s > spanC) ? (s - (spanC + 8'd1)) : s;
    return 16'(MIN_H) + {8'd0, f};
  endfunction

  // BCD increment saturating at 99.
  function automatic logic [7:0] bcdInc(input logic [7:0] v);
    if (v == 8'h99)
      return v;
    else if (v[3:0] == 4'd9)
      return {v[7:4] + 4'd1, 4'd0};
    else
      return {v[7:4], v[3:0] + 4'd1};
  endfunction

  // Event detection against the previous position; 17-bit sums avoid overflow.
  always_comb begin
    wrap = (bus.PipesPosition == 16'(WRAP_X)) && (prevPos != 16'(WRAP_X));
    pass = (({1'b0, bus.PipesPosition} + 17'(PIPE_W)) < 17'(BIRD_X)) &&
           (({1'b0, prevPos} + 17'(PIPE_W)) >= 17'(BIRD_X)) &&
           !scored;
  end

  // The height is loaded on the edge that enters GEN, so PipesLong is
  // already valid during the GEN cycle and NewPipe follows one cycle later.
  always_comb begin
    nextState  = state;
    loadHeight = 1'b0;
    doScore    = 1'b0;
    clrScore   = 1'b0;
    case (state)
      WAIT_START: begin
        if (bus.Start) begin
          nextState  = GEN;
          loadHeight = 1'b1;
        end
      end
      GEN: begin
        nextState = RUN;
      end
      RUN: begin
        // Death outranks wrap and pass; wrap outranks pass.
        if (!bus.Status) begin
          nextState = DEAD;
        end else if (wrap) begin
          nextState  = GEN;
          loadHeight = 1'b1;
        end else if (pass) begin
          doScore = 1'b1;
        end
      end
      DEAD: begin
        if (bus.Start) begin
          nextState  = GEN;
          loadHeight = 1'b1;
          clrScore   = 1'b1;
        end
      end
      default: begin
        nextState = WAIT_START;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      state           <= WAIT_START;
      lfsr            <= SEED;
      prevPos         <= 16'(WRAP_X);
      scored          <= 1'b0;
      bus.PipesLong   <= 16'(DEF_H);
      bus.Score       <= 8'h00;
      bus.NewPipe     <= 1'b0;
      bus.ScoreStrobe <= 1'b0;
    end else begin
      state           <= nextState;
      lfsr            <= lfsrStep(lfsr);
      prevPos         <= bus.PipesPosition;
      bus.NewPipe     <= (state == GEN);
      bus.ScoreStrobe <= doScore && (bus.Score != 8'h99);

      if (loadHeight)
        bus.PipesLong <= heightOf(lfsr[7:0]);

      if (loadHeight)
        scored <= 1'b0;
      else if (doScore)
        scored <= 1'b1;

      if (clrScore)
        bus.Score <= 8'h00;
      else if (doScore)
        bus.Score <= bcdInc(bus.Score);
    end
  end

endmodule

// File: tb/tb_pipe_gap_gen.sv
// Directed bench for pipe_gap_gen: reset values, forced-sample height draws,
// wrap latency, BCD scoring with carry and saturation, death/restart and
// mid-game reset.
module tb_pipe_gap_gen;

  logic clk = 1'b0;
  logic Reset;
  logic [15:0] mLfsr;
  logic [15:0] expLong;
  int tests = 0;
  int failed = 0;

  pipe_gap_gen_if bus();

  pipe_gap_gen dut (
    .clk   (clk),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference LFSR tracking the one inside the design, used to pick the
  // cycle on which a wanted sample byte is present.
  always @(posedge clk) begin
    if (Reset)
      mLfsr <= 16'hACE1;
    else
      mLfsr <= {1'b0, mLfsr[15:1]} ^ (mLfsr[0] ? 16'hB400 : 16'h0000);
  end

  function automatic logic [15:0] expHeight(input logic [7:0] s);
    int v;
    v = int'(s);
    if (v > 200)
      v = v - 201;
    return 16'(40 + v);
  endfunction

  function automatic logic [7:0] toBcd(input int n);
    return 8'(((n / 10) << 4) + (n % 10));
  endfunction

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wrap on the cycle whose LFSR low byte equals target; expect height.
  task automatic hitWrap(input logic [7:0] target, input logic [15:0] height);
    bit hit;
    hit = 1'b0;
    bus.PipesPosition = 16'd641;
    tick();
    for (int i = 0; i < 5000 && !hit; i++) begin
      if (mLfsr[7:0] == target) begin
        hit = 1'b1;
        bus.PipesPosition = 16'd640;
        tick();
        checkVal("forcedHeight", 32'(bus.PipesLong), 32'(height));
        checkVal("newPipeEarly", 32'(bus.NewPipe), 32'd0);
        tick();
        checkVal("newPipePulse", 32'(bus.NewPipe), 32'd1);
      end else begin
        tick();
      end
    end
    if (!hit)
      checkVal("wrapSearchTimeout", 32'd0, 32'd1);
  endtask

  // One pipe cycle: wrap, then a pass at 110->109 (with Status=0 if dead).
  task automatic doRound(input bit dead);
    bus.PipesPosition = 16'd641;
    tick();
    bus.PipesPosition = 16'd640;
    expLong = expHeight(mLfsr[7:0]);
    tick();
    checkVal("roundHeight", 32'(bus.PipesLong), 32'(expLong));
    tick();
    bus.PipesPosition = 16'd110;
    tick();
    bus.PipesPosition = 16'd109;
    bus.Status = !dead;
    tick();
  endtask

  initial begin
    Reset = 1'b1;
    bus.Start = 1'b0;
    bus.Status = 1'b1;
    bus.PipesPosition = 16'd300;
    tick();
    tick();
    Reset = 1'b0;

    // First post-reset cycle
    checkVal("rstLong", 32'(bus.PipesLong), 32'd140);
    checkVal("rstScore", 32'(bus.Score), 32'h00);
    checkVal("rstNewPipe", 32'(bus.NewPipe), 32'd0);
    checkVal("rstStrobe", 32'(bus.ScoreStrobe), 32'd0);
    checkVal("rstLfsr", 32'(dut.lfsr), 32'hACE1);

    // Start now samples 8'hE1 -> 225-201+40 = 64
    bus.Start = 1'b1;
    tick();
    bus.Start = 1'b0;
    checkVal("startHeightE1", 32'(bus.PipesLong), 32'd64);
    checkVal("startNewPipeLow", 32'(bus.NewPipe), 32'd0);
    tick();
    checkVal("startNewPipe", 32'(bus.NewPipe), 32'd1);
    bus.Start = 1'b1;
    tick();
    bus.Start = 1'b0;
    checkVal("newPipeOneCycle", 32'(bus.NewPipe), 32'd0);
    tick();
    checkVal("startIgnoredPulse", 32'(bus.NewPipe), 32'd0);
    checkVal("startIgnoredLong", 32'(bus.PipesLong), 32'd64);

    hitWrap(8'h64, 16'd140);
    hitWrap(8'hC8, 16'd240);

    // First pass: 00 -> 01 with a single strobe, no repeat while held
    doRound(1'b0);
    checkVal("score01", 32'(bus.Score), 32'h01);
    checkVal("strobe01", 32'(bus.ScoreStrobe), 32'd1);
    tick();
    checkVal("strobeOneCycle", 32'(bus.ScoreStrobe), 32'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      checkVal("holdNoStrobe", 32'(bus.ScoreStrobe), 32'd0);
    end
    checkVal("holdScore", 32'(bus.Score), 32'h01);

    for (int n = 2; n <= 99; n++) begin
      doRound(1'b0);
      checkVal("scoreBcd", 32'(bus.Score), 32'(toBcd(n)));
      checkVal("scoreStrobe", 32'(bus.ScoreStrobe), 32'd1);
    end

    // Saturation at 99
    doRound(1'b0);
    checkVal("score99Hold", 32'(bus.Score), 32'h99);
    checkVal("score99NoStrobe", 32'(bus.ScoreStrobe), 32'd0);

    // Status drops on the pass cycle: dead, no score
    doRound(1'b1);
    checkVal("deadScore", 32'(bus.Score), 32'h99);
    checkVal("deadNoStrobe", 32'(bus.ScoreStrobe), 32'd0);
    bus.Status = 1'b1;
    bus.PipesPosition = 16'd641;
    tick();
    bus.PipesPosition = 16'd640;
    tick();
    tick();
    checkVal("deadFreezeLong", 32'(bus.PipesLong), 32'(expLong));
    checkVal("deadNoNewPipe", 32'(bus.NewPipe), 32'd0);

    // Restart from DEAD
    bus.Start = 1'b1;
    expLong = expHeight(mLfsr[7:0]);
    tick();
    bus.Start = 1'b0;
    checkVal("restartScore", 32'(bus.Score), 32'h00);
    checkVal("restartLong", 32'(bus.PipesLong), 32'(expLong));
    tick();
    checkVal("restartNewPipe", 32'(bus.NewPipe), 32'd1);

    // Reach 37 then reset mid-game while the strobe is high
    for (int n = 1; n <= 37; n++)
      doRound(1'b0);
    checkVal("score37", 32'(bus.Score), 32'h37);
    checkVal("strobe37", 32'(bus.ScoreStrobe), 32'd1);
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    checkVal("midRstLong", 32'(bus.PipesLong), 32'd140);
    checkVal("midRstScore", 32'(bus.Score), 32'h00);
    checkVal("midRstStrobe", 32'(bus.ScoreStrobe), 32'd0);
    checkVal("midRstNewPipe", 32'(bus.NewPipe), 32'd0);

    // Back in WAIT_START: a wrap does nothing
    bus.PipesPosition = 16'd641;
    tick();
    bus.PipesPosition = 16'd640;
    tick();
    tick();
    tick();
    checkVal("waitNoNewPipe", 32'(bus.NewPipe), 32'd0);
    checkVal("waitLong", 32'(bus.PipesLong), 32'd140);
    bus.Start = 1'b1;
    expLong = expHeight(mLfsr[7:0]);
    tick();
    bus.Start = 1'b0;
    checkVal("waitStartLong", 32'(bus.PipesLong), 32'(expLong));

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
